// File: rtl/soc_reset_pkg.sv
// Shared types for the HPS-to-fabric reset sequencer: FSM states, reset-cause
// codes and the saturating reset-entry counter helper.
package soc_reset_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        WAIT_SRC,
        RELEASE,
        RUN
    } reset_state_t;

    localparam logic [1:0] CAUSE_RST  = 2'b00;
    localparam logic [1:0] CAUSE_HPS  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    localparam int RST_COUNT_W = 8;

    function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Multi-flop synchroniser for the asynchronous HPS reset. Clears to 0, so the
// HPS reset reads as asserted until a deasserted level has crossed the chain.
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/hps_fabric_reset_sequencer.sv
// Drives the fabric reset tree from h2f_reset_n and a software request: hold,
// then staggered per-domain release. Define HPS_RESET_CAUSE_EN for cause/count.
module hps_fabric_reset_sequencer
    import soc_reset_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h2f_reset_n,
    input  logic                   sw_req,
    output logic                   sw_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_released,
    output logic                   busy
`ifdef HPS_RESET_CAUSE_EN
    ,
    output logic [1:0]             reset_cause,
    output logic [RST_COUNT_W-1:0] reset_count
`endif
);

    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W    = $clog2(STAGGER_CYCLES * NUM_DOMAINS + 1);
    localparam int LAST_REL = (NUM_DOMAINS - 1) * STAGGER_CYCLES;

    logic w_hps_sync_n;
    logic w_src_hps;
    logic w_src_any;

    reset_state_t           r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [STG_W-1:0]       r_stg_cnt;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic                   r_all;
    logic                   r_busy;
    logic                   r_ack;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (h2f_reset_n),
        .q   (w_hps_sync_n)
    );

    assign w_src_hps = ~w_hps_sync_n;
    assign w_src_any = w_src_hps | sw_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ASSERT;
            r_hold_cnt <= '0;
            r_stg_cnt  <= '0;
            r_dom      <= '0;
            r_all      <= 1'b0;
            r_busy     <= 1'b1;
            r_ack      <= 1'b0;
        end else begin
            case (r_state)
                // A source seen while already holding only extends WAIT_SRC; the hold is a minimum.
                ASSERT: begin
                    r_dom <= '0;
                    if (r_hold_cnt == HOLD_W'(HOLD_CYCLES)) begin
                        r_state <= WAIT_SRC;
                        r_ack   <= sw_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                WAIT_SRC: begin
                    if (w_src_any) begin
                        r_ack <= sw_req;
                    end else begin
                        r_ack     <= 1'b0;
                        r_state   <= RELEASE;
                        r_stg_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (w_src_any) begin
                        r_state    <= ASSERT;
                        r_hold_cnt <= '0;
                        r_dom      <= '0;
                    end else begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (r_stg_cnt == STG_W'(i * STAGGER_CYCLES)) begin
                                r_dom[i] <= 1'b1;
                            end
                        end
                        if (r_stg_cnt == STG_W'(LAST_REL)) begin
                            r_state <= RUN;
                            r_all   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stg_cnt <= r_stg_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_src_any) begin
                        r_state    <= ASSERT;
                        r_hold_cnt <= '0;
                        r_dom      <= '0;
                        r_all      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                default: r_state <= ASSERT;
            endcase
        end
    end

    assign domain_rst_n = r_dom;
    assign all_released = r_all;
    assign busy         = r_busy;
    assign sw_ack       = r_ack;

`ifdef HPS_RESET_CAUSE_EN
    logic                   w_enter_assert;
    logic [1:0]             r_cause;
    logic [RST_COUNT_W-1:0] r_count;

    assign w_enter_assert = w_src_any && (r_state == RUN || r_state == RELEASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= CAUSE_RST;
            r_count <= '0;
        end else if (w_enter_assert) begin
            r_cause <= {sw_req, w_src_hps};
            r_count <= sat_inc(r_count);
        end
    end

    assign reset_cause = r_cause;
    assign reset_count = r_count;
`else
    // Cause tracking not built: no extra state or ports.
`endif

endmodule

// File: tb/tb_hps_fabric_reset_sequencer.sv
// Scoreboard bench for hps_fabric_reset_sequencer (default parameters); the
// cause/count checks are compiled in when HPS_RESET_CAUSE_EN is defined.
module tb_hps_fabric_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       h2f_reset_n;
    logic       sw_req;
    logic       sw_ack;
    logic [2:0] domain_rst_n;
    logic       all_released;
    logic       busy;
`ifdef HPS_RESET_CAUSE_EN
    logic [1:0] reset_cause;
    logic [7:0] reset_count;
`endif

    always #10 clk = ~clk;

    hps_fabric_reset_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .h2f_reset_n  (h2f_reset_n),
        .sw_req       (sw_req),
        .sw_ack       (sw_ack),
        .domain_rst_n (domain_rst_n),
        .all_released (all_released),
        .busy         (busy)
`ifdef HPS_RESET_CAUSE_EN
        ,
        .reset_cause  (reset_cause),
        .reset_count  (reset_count)
`endif
    );

    typedef struct {
        string      tag;
        logic [2:0] dom;
        logic       all_rel;
        logic       busy;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected outputs for the next active edge; the monitor pops them after it.
    task automatic cyc(input string tag, input logic [2:0] dom, input logic ar,
                       input logic bz, input logic ack);
        sb_q.push_back('{tag, dom, ar, bz, ack});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input string tag);
        repeat (n) cyc(tag, 3'b000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_release(input string tag);
        repeat (8) cyc(tag, 3'b001, 1'b0, 1'b1, 1'b0);
        repeat (8) cyc(tag, 3'b011, 1'b0, 1'b1, 1'b0);
        cyc(tag, 3'b111, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_run(input int n, input string tag);
        repeat (n) cyc(tag, 3'b111, 1'b1, 1'b0, 1'b0);
    endtask

    // One-cycle HPS reset pulse from RUN: two more RUN edges, then ASSERT.
    task automatic hps_pulse(input string tag, input logic [2:0] dom_before);
        h2f_reset_n = 1'b0;
        cyc(tag, dom_before, dom_before == 3'b111, dom_before != 3'b111, 1'b0);
        h2f_reset_n = 1'b1;
        cyc(tag, dom_before, dom_before == 3'b111, dom_before != 3'b111, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".dom"},  32'(domain_rst_n), 32'(e.dom));
                check({e.tag, ".all"},  32'(all_released), 32'(e.all_rel));
                check({e.tag, ".busy"}, 32'(busy),         32'(e.busy));
                check({e.tag, ".ack"},  32'(sw_ack),       32'(e.ack));
            end
        end
    end

    initial begin
`ifdef HPS_RESET_CAUSE_EN
        int n;
        int timeouts;
`endif
        rst         = 1'b1;
        h2f_reset_n = 1'b1;
        sw_req      = 1'b0;

        // Power-on: reset values, then 000 through edge 17, 001@18, 011@26, 111@34.
        hold(4, "rst");
        rst = 1'b0;
        hold(18, "t1");
        run_release("t1");
        idle_run(3, "t1run");

        // HPS pulse from RUN: domains fall on the third edge, full resequence.
        hps_pulse("t2pre", 3'b111);
        hold(19, "t2");
`ifdef HPS_RESET_CAUSE_EN
        check("t2.cause", 32'(reset_cause), 32'h1);
        check("t2.count", 32'(reset_count), 32'd1);
`endif
        run_release("t2");
        idle_run(2, "t2run");

        // Software request: hold, ack stalls in WAIT_SRC, dropping req releases.
        sw_req = 1'b1;
        hold(17, "t3");
        repeat (3) cyc("t3ack", 3'b000, 1'b0, 1'b1, 1'b1);
        sw_req = 1'b0;
        cyc("t3drop", 3'b000, 1'b0, 1'b1, 1'b0);
        run_release("t3");
`ifdef HPS_RESET_CAUSE_EN
        check("t3.cause", 32'(reset_cause), 32'h2);
        check("t3.count", 32'(reset_count), 32'd2);
`endif
        idle_run(2, "t3run");

        // HPS reset during RELEASE after 001: hold restarts, release re-runs.
        hps_pulse("t4pre", 3'b111);
        hold(19, "t4a");
        repeat (2) cyc("t4rel", 3'b001, 1'b0, 1'b1, 1'b0);
        hps_pulse("t4mid", 3'b001);
        hold(19, "t4b");
        run_release("t4");
`ifdef HPS_RESET_CAUSE_EN
        check("t4.cause", 32'(reset_cause), 32'h1);
        check("t4.count", 32'(reset_count), 32'd4);
`endif
        idle_run(2, "t4run");

        // rst mid-RELEASE at 011: immediate return to reset values.
        hps_pulse("t5pre", 3'b111);
        hold(19, "t5a");
        repeat (8) cyc("t5rel", 3'b001, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc("t5rel", 3'b011, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        hold(2, "t5rst");
`ifdef HPS_RESET_CAUSE_EN
        check("t5.cause", 32'(reset_cause), 32'h0);
        check("t5.count", 32'(reset_count), 32'd0);
`endif
        rst = 1'b0;
        hold(18, "t5b");
        run_release("t5");
        idle_run(2, "t5run");

`ifdef HPS_RESET_CAUSE_EN
        // Both sources present at the entry edge, then saturate the counter.
        h2f_reset_n = 1'b0;
        tick();
        tick();
        sw_req = 1'b1;
        tick();
        check("t6.cause", 32'(reset_cause), 32'h3);
        check("t6.count", 32'(reset_count), 32'd1);
        h2f_reset_n = 1'b1;
        sw_req      = 1'b0;
        timeouts    = 0;
        repeat (299) begin
            n = 0;
            while (!all_released && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) timeouts++;
            sw_req = 1'b1;
            tick();
            sw_req = 1'b0;
        end
        check("t6.timeouts", 32'(timeouts), 32'd0);
        check("t6.sat", 32'(reset_count), 32'd255);
`endif

        tick();
        check("sb.drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
